clap_counter: RTL

- Upstream stage of the clap-controlled light path.
- Consumes a stream of rectified microphone amplitude samples and detects individual claps with a threshold and hysteresis, rejecting echo and ringing with a hold-off window.
- Groups consecutive claps separated by less than a gap timeout into one burst.
- Presents the burst's clap count on a valid/ready output. That output drives the toggle-light stage's claps_data/claps_valid/claps_ready input directly.

---
 rtl/clap_counter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/clap_counter.sv
// Clap detector: threshold/hysteresis detection with echo hold-off, groups claps
// into bursts and hands the burst count downstream over valid/ready.
module clap_counter #(
  parameter int SAMPLE_WIDTH   = 12,
  parameter int CLAPS_WIDTH    = 16,
  parameter int THRESH_HI      = 2048,
  parameter int THRESH_LO      = 1024,
  parameter int HOLDOFF_CYCLES = 2500000,
  parameter int GAP_CYCLES     = 25000000,
  parameter int MAX_CLAPS      = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    sample_valid,
  output logic [CLAPS_WIDTH-1:0]  claps_data,
  output logic                    claps_valid,
  input  logic                    claps_ready,
  output logic                    clap_pulse,
  output logic                    busy
);

  localparam int TIMER_MAX = (HOLDOFF_CYCLES > GAP_CYCLES) ? HOLDOFF_CYCLES : GAP_CYCLES;
  localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [SAMPLE_WIDTH-1:0] HI_LEVEL    = SAMPLE_WIDTH'(THRESH_HI);
  localparam logic [SAMPLE_WIDTH-1:0] LO_LEVEL    = SAMPLE_WIDTH'(THRESH_LO);
  localparam logic [TW-1:0]           HOLD_RELOAD = TW'(HOLDOFF_CYCLES - 1);
  localparam logic [TW-1:0]           GAP_RELOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [CLAPS_WIDTH-1:0]  COUNT_MAX   = CLAPS_WIDTH'(MAX_CLAPS);

  typedef enum logic [1:0] {IDLE, HOLDOFF, GAP, EMIT} state_t;

  state_t                 r_state, w_stateNext;
  logic [CLAPS_WIDTH-1:0] r_count, w_countNext;
  logic [TW-1:0]          r_timer, w_timerNext;
  logic                   r_armed, w_armedNext;
  logic                   r_valid, w_validNext;
  logic [CLAPS_WIDTH-1:0] r_data, w_dataNext;
  logic                   r_pulse, w_pulseNext;
  logic                   w_listening;
  logic                   w_event;

  assign w_listening = (r_state == IDLE) || (r_state == GAP);
  assign w_event     = w_listening && r_armed && sample_valid && (sample_data >= HI_LEVEL);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_timer <= '0;
      r_armed <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      r_timer <= w_timerNext;
      r_armed <= w_armedNext;
      r_valid <= w_validNext;
      r_data  <= w_dataNext;
      r_pulse <= w_pulseNext;
    end
  end

  // A clap on the final gap cycle extends the burst instead of emitting it.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_timerNext = r_timer;
    w_armedNext = r_armed;
    w_validNext = r_valid;
    w_dataNext  = r_data;
    w_pulseNext = 1'b0;

    if (w_listening && sample_valid && (sample_data < LO_LEVEL)) begin
      w_armedNext = 1'b1;
    end
    if (w_event) begin
      w_armedNext = 1'b0;
      w_pulseNext = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_event) begin
          w_countNext = CLAPS_WIDTH'(1);
          w_timerNext = HOLD_RELOAD;
          w_stateNext = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (r_timer == '0) begin
          w_timerNext = GAP_RELOAD;
          w_stateNext = GAP;
        end else begin
          w_timerNext = r_timer - 1'b1;
        end
      end
      GAP: begin
        if (w_event) begin
          w_countNext = (r_count >= COUNT_MAX) ? COUNT_MAX : r_count + CLAPS_WIDTH'(1);
          w_timerNext = HOLD_RELOAD;
          w_stateNext = HOLDOFF;
        end else if (r_timer == '0) begin
          w_dataNext  = r_count;
          w_validNext = 1'b1;
          w_stateNext = EMIT;
        end else begin
          w_timerNext = r_timer - 1'b1;
        end
      end
      EMIT: begin
        if (claps_ready) begin
          w_validNext = 1'b0;
          w_countNext = '0;
          w_armedNext = 1'b0;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign claps_data  = r_data;
  assign claps_valid = r_valid;
  assign clap_pulse  = r_pulse;
  assign busy        = (r_state != IDLE);

endmodule
